nmcu_instr_queue: RTL and testbench

Instruction and response buffering stage between the CPU/chiplet link and the NMCU control unit decoder.
- Instruction path: buffers CPU instructions in a DEPTH-entry first-word-fall-through FIFO and presents them to the decoder with valid/ready.
- Response path: registers decoder responses toward the CPU in a one-entry pipe slice.
- Tracks the count of issued-but-unanswered instructions.
- Blocks all new traffic after a HALT response until flushed.

---
 rtl/nmcu_instr_queue.sv | 130 +++++++++++++
 tb/tb_nmcu_instr_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_instr_queue.sv
// Instruction/response buffering between the CPU link and the NMCU decoder:
// FWFT instruction FIFO, one-entry response slice, outstanding count, halt gate.
package instr_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_t;

  typedef struct packed {
    logic [1:0] status;
    logic [5:0] rsvd;
    logic [7:0] data;
  } nmcu_cpu_resp_t;
endpackage

module nmcu_instr_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_instr_valid_i,
  input  instr_pkg::instruction_t    cpu_instr_i,
  output logic                       cpu_instr_ready_o,
  output logic                       dec_instr_valid_o,
  output instr_pkg::instruction_t    dec_instr_o,
  input  logic                       dec_instr_ready_i,
  input  logic                       dec_resp_valid_i,
  input  instr_pkg::nmcu_cpu_resp_t  dec_resp_i,
  output logic                       dec_resp_ready_o,
  output logic                       cpu_resp_valid_o,
  output instr_pkg::nmcu_cpu_resp_t  cpu_resp_o,
  input  logic                       cpu_resp_ready_i,
  input  logic                       flush_i,
  output logic                       halted_o,
  output logic [CNT_W-1:0]           occupancy_o,
  output logic [CNT_W-1:0]           outstanding_o
);
  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  instr_pkg::instruction_t   mem_reg [DEPTH];
  instr_pkg::nmcu_cpu_resp_t resp_reg, resp_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] occ_reg, occ_next, out_reg, out_next;
  logic             halted_reg, halted_next, full_reg, full_next;
  logic             push, pop, rsp_in, rsp_out, halt_rsp;

  assign cpu_instr_ready_o = (occ_reg != CNT_W'(DEPTH)) & ~halted_reg & ~flush_i;
  assign dec_instr_valid_o = (occ_reg != '0) & ~halted_reg;
  assign dec_instr_o       = mem_reg[rd_ptr_reg];
  assign dec_resp_ready_o  = ~full_reg | cpu_resp_ready_i;
  assign cpu_resp_valid_o  = full_reg;
  assign cpu_resp_o        = resp_reg;
  assign halted_o          = halted_reg;
  assign occupancy_o       = occ_reg;
  assign outstanding_o     = out_reg;

  assign push     = cpu_instr_valid_i & cpu_instr_ready_o;
  assign pop      = dec_instr_valid_o & dec_instr_ready_i;
  assign rsp_in   = dec_resp_valid_i & dec_resp_ready_o;
  assign rsp_out  = full_reg & cpu_resp_ready_i;
  assign halt_rsp = rsp_in & (dec_resp_i.status == 2'b01);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_next = occ_reg + CNT_W'(1);
      2'b01:   occ_next = occ_reg - CNT_W'(1);
      default: occ_next = occ_reg;
    endcase
    // Flush drops the queue but a pop in the same cycle still counts as issued.
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      occ_next    = '0;
    end
  end

  always_comb begin
    out_next = out_reg;
    if (pop && !rsp_in && out_reg != CNT_MAX)
      out_next = out_reg + CNT_W'(1);
    else if (rsp_in && !pop && out_reg != '0)
      out_next = out_reg - CNT_W'(1);
  end

  always_comb begin
    resp_next = resp_reg;
    full_next = full_reg;
    if (rsp_in) begin
      resp_next = dec_resp_i;
      full_next = 1'b1;
    end else if (rsp_out) begin
      full_next = 1'b0;
    end
    // A HALT arriving with a flush wins.
    if (halt_rsp)     halted_next = 1'b1;
    else if (flush_i) halted_next = 1'b0;
    else              halted_next = halted_reg;
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= cpu_instr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      out_reg    <= '0;
      halted_reg <= 1'b0;
      full_reg   <= 1'b0;
      resp_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      out_reg    <= out_next;
      halted_reg <= halted_next;
      full_reg   <= full_next;
      resp_reg   <= resp_next;
    end
  end
endmodule

// File: tb/tb_nmcu_instr_queue.sv
// Bench for nmcu_instr_queue: per-cycle vector table plus hand-written corner
// sequences, with a queue-based scoreboard watching every cycle.
module tb_nmcu_instr_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_instr_valid_i = 1'b0;
  instr_pkg::instruction_t cpu_instr_i = '0;
  logic cpu_instr_ready_o, dec_instr_valid_o;
  instr_pkg::instruction_t dec_instr_o;
  logic dec_instr_ready_i = 1'b0;
  logic dec_resp_valid_i = 1'b0;
  instr_pkg::nmcu_cpu_resp_t dec_resp_i = '0;
  logic dec_resp_ready_o, cpu_resp_valid_o;
  instr_pkg::nmcu_cpu_resp_t cpu_resp_o;
  logic cpu_resp_ready_i = 1'b0;
  logic flush_i = 1'b0;
  logic halted_o;
  logic [CNT_W-1:0] occupancy_o, outstanding_o;

  nmcu_instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_instr_valid_i(cpu_instr_valid_i), .cpu_instr_i(cpu_instr_i),
    .cpu_instr_ready_o(cpu_instr_ready_o),
    .dec_instr_valid_o(dec_instr_valid_o), .dec_instr_o(dec_instr_o),
    .dec_instr_ready_i(dec_instr_ready_i),
    .dec_resp_valid_i(dec_resp_valid_i), .dec_resp_i(dec_resp_i),
    .dec_resp_ready_o(dec_resp_ready_o),
    .cpu_resp_valid_o(cpu_resp_valid_o), .cpu_resp_o(cpu_resp_o),
    .cpu_resp_ready_i(cpu_resp_ready_i),
    .flush_i(flush_i), .halted_o(halted_o),
    .occupancy_o(occupancy_o), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Scoreboard model, sampled at the falling edge.
  instr_pkg::instruction_t   instr_q[$];
  instr_pkg::nmcu_cpu_resp_t resp_q[$];
  int   m_out = 0;
  logic m_halt = 1'b0;
  int   cyc = 0;

  initial begin
    logic e_cready, e_dvalid, e_rready, do_push, do_pop, do_rin, do_rout;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        instr_q.delete();
        resp_q.delete();
        m_out  = 0;
        m_halt = 1'b0;
        chk("rst_occ", cyc, 32'(occupancy_o), 0);
        chk("rst_out", cyc, 32'(outstanding_o), 0);
        chk("rst_rvalid", cyc, 32'(cpu_resp_valid_o), 0);
        chk("rst_dvalid", cyc, 32'(dec_instr_valid_o), 0);
      end else begin
        e_cready = (instr_q.size() != DEPTH) && !m_halt && !flush_i;
        e_dvalid = (instr_q.size() != 0) && !m_halt;
        e_rready = (resp_q.size() == 0) || cpu_resp_ready_i;
        chk("sb_cready", cyc, 32'(cpu_instr_ready_o), 32'(e_cready));
        chk("sb_dvalid", cyc, 32'(dec_instr_valid_o), 32'(e_dvalid));
        chk("sb_rready", cyc, 32'(dec_resp_ready_o), 32'(e_rready));
        chk("sb_rvalid", cyc, 32'(cpu_resp_valid_o), 32'(resp_q.size() != 0));
        chk("sb_occ", cyc, 32'(occupancy_o), 32'(instr_q.size()));
        chk("sb_out", cyc, 32'(outstanding_o), 32'(m_out));
        chk("sb_halt", cyc, 32'(halted_o), 32'(m_halt));
        if (resp_q.size() != 0) chk("sb_resp", cyc, 32'(cpu_resp_o), 32'(resp_q[0]));
        do_push = cpu_instr_valid_i && e_cready;
        do_pop  = e_dvalid && dec_instr_ready_i;
        do_rin  = dec_resp_valid_i && e_rready;
        do_rout = (resp_q.size() != 0) && cpu_resp_ready_i;
        if (do_pop) begin
          chk("sb_instr", cyc, 32'(dec_instr_o), 32'(instr_q[0]));
          void'(instr_q.pop_front());
        end
        if (flush_i) instr_q.delete();
        if (do_push) instr_q.push_back(cpu_instr_i);
        if (do_rout) void'(resp_q.pop_front());
        if (do_rin) resp_q.push_back(dec_resp_i);
        if (do_pop && !do_rin && m_out < (1 << CNT_W) - 1) m_out++;
        else if (do_rin && !do_pop && m_out > 0) m_out--;
        if (do_rin && dec_resp_i.status == 2'b01) m_halt = 1'b1;
        else if (flush_i) m_halt = 1'b0;
      end
    end
  end

  typedef struct {
    logic cv; logic [31:0] instr; logic dr; logic rv; logic [1:0] st; logic [7:0] dat;
    logic cr; logic fl;
    int occ; int outs; logic halt; logic cready; logic dvalid; logic rready; logic rvalid;
  } vec_t;
  vec_t vecs[$];

  task automatic drive(input logic cv, input logic [31:0] ins, input logic dr, input logic rv,
                       input logic [1:0] st, input logic [7:0] dat, input logic cr, input logic fl);
    @(posedge clk);
    #1;
    cpu_instr_valid_i = cv;
    cpu_instr_i       = instr_pkg::instruction_t'(ins);
    dec_instr_ready_i = dr;
    dec_resp_valid_i  = rv;
    dec_resp_i        = '{status: st, rsvd: 6'd0, data: dat};
    cpu_resp_ready_i  = cr;
    flush_i           = fl;
  endtask

  initial begin
    vec_t v;
    // cv instr dr rv st dat cr fl | occ out halt cready dvalid rready rvalid
    vecs.push_back('{1, 32'hA000_000A, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 0});
    vecs.push_back('{1, 32'hB000_000B, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{1, 32'hC000_000C, 0, 0, 0, 8'h00, 0, 0, 2, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         0, 0, 0, 8'h00, 0, 0, 3, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         1, 0, 0, 8'h00, 0, 0, 3, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         1, 0, 0, 8'h00, 0, 0, 2, 1, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         1, 0, 0, 8'h00, 0, 0, 1, 2, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         0, 1, 0, 8'h11, 0, 0, 0, 3, 0, 1, 0, 1, 0});
    vecs.push_back('{0, 32'h0,         0, 1, 0, 8'h22, 0, 0, 0, 2, 0, 1, 0, 0, 1});
    vecs.push_back('{0, 32'h0,         0, 1, 0, 8'h22, 1, 0, 0, 2, 0, 1, 0, 1, 1});
    vecs.push_back('{0, 32'h0,         0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 1, 1});
    vecs.push_back('{0, 32'h0,         0, 1, 0, 8'h33, 1, 0, 0, 1, 0, 1, 0, 1, 0});
    vecs.push_back('{1, 32'hD000_000D, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 1});
    vecs.push_back('{1, 32'hE000_000E, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         1, 0, 0, 8'h00, 1, 0, 2, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         1, 1, 0, 8'h44, 1, 0, 1, 1, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 32'h0,         0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 1, 1});
    vecs.push_back('{0, 32'h0,         0, 1, 0, 8'h55, 1, 0, 0, 1, 0, 1, 0, 1, 0});
    vecs.push_back('{0, 32'h0,         0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 1});
    vecs.push_back('{0, 32'h0,         0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1, 0});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.cv, v.instr, v.dr, v.rv, v.st, v.dat, v.cr, v.fl);
      #1;
      chk("tv_occ", i, 32'(occupancy_o), 32'(v.occ));
      chk("tv_out", i, 32'(outstanding_o), 32'(v.outs));
      chk("tv_halt", i, 32'(halted_o), 32'(v.halt));
      chk("tv_cready", i, 32'(cpu_instr_ready_o), 32'(v.cready));
      chk("tv_dvalid", i, 32'(dec_instr_valid_o), 32'(v.dvalid));
      chk("tv_rready", i, 32'(dec_resp_ready_o), 32'(v.rready));
      chk("tv_rvalid", i, 32'(cpu_resp_valid_o), 32'(v.rvalid));
      $display("vec %0d: occ=%0d out=%0d rvalid=%0d", i, occupancy_o, outstanding_o, cpu_resp_valid_o);
    end

    // Fill, reject a push while popping from full, then wrap the pointers.
    for (int i = 0; i < DEPTH; i++) drive(1, 32'h0F00_0000 + 32'(i), 0, 0, 0, 0, 1, 0);
    drive(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 0);
    #1;
    chk("full_cready", 0, 32'(cpu_instr_ready_o), 0);
    chk("full_occ", 0, 32'(occupancy_o), 4);
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, 1, 1, 0, 8'(i), 1, 0);
      #1;
      if (i == 0) chk("reject_occ", 0, 32'(occupancy_o), 3);
      $display("wrap %0d: head=%h occ=%0d", i, dec_instr_o, occupancy_o);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 8'h60, 1, 0);
    drive(0, 0, 0, 1, 0, 8'h61, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("wrap_occ", 0, 32'(occupancy_o), 0);
    chk("wrap_out", 0, 32'(outstanding_o), 0);

    // HALT blocks traffic, the HALT response still reaches the CPU, flush releases.
    drive(1, 32'h1111_0001, 0, 0, 0, 0, 1, 0);
    drive(1, 32'h1111_0002, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 2'b01, 8'hAA, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("halt_set", 0, 32'(halted_o), 1);
    chk("halt_dvalid", 0, 32'(dec_instr_valid_o), 0);
    chk("halt_cready", 0, 32'(cpu_instr_ready_o), 0);
    chk("halt_rvalid", 0, 32'(cpu_resp_valid_o), 1);
    chk("halt_resp", 0, 32'(cpu_resp_o), 32'h0000_40AA);
    drive(1, 32'h1111_0003, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("halt_keep", 0, 32'(occupancy_o), 2);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("flush_occ", 0, 32'(occupancy_o), 0);
    chk("flush_halt", 0, 32'(halted_o), 0);

    // HALT and flush in the same cycle: halt wins.
    drive(1, 32'h2222_0001, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 2'b01, 8'hBB, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("hf_halt", 0, 32'(halted_o), 1);
    chk("hf_occ", 0, 32'(occupancy_o), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("hf_clear", 0, 32'(halted_o), 0);

    // Asynchronous reset mid-burst with a pending response.
    for (int i = 0; i < 3; i++) drive(1, 32'h3333_0000 + 32'(i), 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 8'h77, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_occ", 0, 32'(occupancy_o), 3);
    chk("pre_rst_rvalid", 0, 32'(cpu_resp_valid_o), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_occ_now", 0, 32'(occupancy_o), 0);
    chk("rst_out_now", 0, 32'(outstanding_o), 0);
    chk("rst_rvalid_now", 0, 32'(cpu_resp_valid_o), 0);
    chk("rst_cready_now", 0, 32'(cpu_instr_ready_o), 1);
    chk("rst_rready_now", 0, 32'(dec_resp_ready_o), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("post_rst_occ", 0, 32'(occupancy_o), 0);
    chk("post_rst_dvalid", 0, 32'(dec_instr_valid_o), 0);
    chk("post_rst_cready", 0, 32'(cpu_instr_ready_o), 1);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
